// File: rtl/axi4_ram_slave.sv
// AXI4 responder backed by a byte-strobed on-chip RAM.
// Independent read and write FSMs, one outstanding burst each, FIXED/INCR/WRAP.
module axi4_ram_slave #(
  parameter int BYTES    = 4,
  parameter int ADDR_W   = 12,
  parameter int ID_WIDTH = 4,
  localparam int IDW     = (ID_WIDTH < 1) ? 1 : ID_WIDTH
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [IDW-1:0]       awId,
  input  logic [ADDR_W-1:0]    awAddr,
  input  logic [7:0]           awLen,
  input  logic [2:0]           awSize,
  input  logic [1:0]           awBurst,
  input  logic                 awValid,
  output logic                 awReady,
  input  logic [8*BYTES-1:0]   wData,
  input  logic [BYTES-1:0]     wStrb,
  input  logic                 wLast,
  input  logic                 wValid,
  output logic                 wReady,
  output logic [IDW-1:0]       bId,
  output logic [1:0]           bResp,
  output logic                 bValid,
  input  logic                 bReady,
  input  logic [IDW-1:0]       arId,
  input  logic [ADDR_W-1:0]    arAddr,
  input  logic [7:0]           arLen,
  input  logic [2:0]           arSize,
  input  logic [1:0]           arBurst,
  input  logic                 arValid,
  output logic                 arReady,
  output logic [IDW-1:0]       rId,
  output logic [8*BYTES-1:0]   rData,
  output logic [1:0]           rResp,
  output logic                 rLast,
  output logic                 rValid,
  input  logic                 rReady
);

  localparam int AXSIZE_MAX = $clog2(BYTES);
  localparam int WORD_W     = ADDR_W - AXSIZE_MAX;
  localparam int DEPTH      = 1 << WORD_W;

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [31:0] inc, span, lower, nxt;
    inc   = 32'd1 << size;
    span  = (32'(len) + 32'd1) * inc;
    lower = 32'(addr) & ~(span - 32'd1);
    nxt   = (32'(addr) & ~(inc - 32'd1)) + inc;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = ADDR_W'((nxt == lower + span) ? lower : nxt);
      default: next_addr = ADDR_W'(nxt);
    endcase
  endfunction

  function automatic logic bad_cmd(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    bad_cmd = (size > 3'(AXSIZE_MAX)) || (burst == 2'b11) ||
              (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  logic [8*BYTES-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  w_state_t          w_state, w_state_next;
  logic [IDW-1:0]    w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_cmd_err, w_last_err;
  logic              aw_hs, w_hs;

  assign aw_hs = awValid && awReady;
  assign w_hs  = wValid && wReady;

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_INIT;
    else        w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    awReady      = 1'b0;
    wReady       = 1'b0;
    bValid       = 1'b0;
    case (w_state)
      W_INIT: w_state_next = W_IDLE;
      W_IDLE: begin
        awReady = 1'b1;
        if (awValid) w_state_next = W_DATA;
      end
      W_DATA: begin
        wReady = 1'b1;
        if (wValid && w_cnt == w_len) w_state_next = W_RESP;
      end
      W_RESP: begin
        bValid = 1'b1;
        if (bReady) w_state_next = W_IDLE;
      end
      default: w_state_next = W_INIT;
    endcase
  end

  // A wLast mismatch is reported but does not stop the burst from being stored.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_id       <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_cnt      <= '0;
      w_cmd_err  <= 1'b0;
      w_last_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id       <= awId;
        w_addr     <= awAddr;
        w_len      <= awLen;
        w_size     <= awSize;
        w_burst    <= awBurst;
        w_cnt      <= '0;
        w_cmd_err  <= bad_cmd(awLen, awSize, awBurst);
        w_last_err <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (wLast != (w_cnt == w_len)) w_last_err <= 1'b1;
      end
    end
  end

  assign bId   = w_id;
  assign bResp = (bValid && (w_cmd_err || w_last_err)) ? 2'b10 : 2'b00;

  always_ff @(posedge aclk) begin
    if (!areset && w_hs && !w_cmd_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wStrb[b]) mem[w_addr[ADDR_W-1:AXSIZE_MAX]][8*b +: 8] <= wData[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t          r_state, r_state_next;
  logic [IDW-1:0]    r_id;
  logic [ADDR_W-1:0] r_addr, r_addr_next;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err, r_final, ar_hs, r_hs, ar_bad;
  logic [8*BYTES-1:0] r_data;

  assign ar_hs       = arValid && arReady;
  assign r_hs        = rValid && rReady;
  assign r_final     = (r_cnt == r_len);
  assign r_addr_next = next_addr(r_addr, r_len, r_size, r_burst);
  assign ar_bad      = bad_cmd(arLen, arSize, arBurst);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_INIT;
    else        r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    arReady      = 1'b0;
    rValid       = 1'b0;
    case (r_state)
      R_INIT: r_state_next = R_IDLE;
      R_IDLE: begin
        arReady = 1'b1;
        if (arValid) r_state_next = R_DATA;
      end
      R_DATA: begin
        rValid = 1'b1;
        if (rReady && r_final) r_state_next = R_IDLE;
      end
      default: r_state_next = R_INIT;
    endcase
  end

  // RAM is only sampled on a handshake, so a stalled beat keeps its data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= arId;
      r_addr  <= arAddr;
      r_len   <= arLen;
      r_size  <= arSize;
      r_burst <= arBurst;
      r_cnt   <= '0;
      r_err   <= ar_bad;
      r_data  <= ar_bad ? '0 : mem[arAddr[ADDR_W-1:AXSIZE_MAX]];
    end else if (r_hs && !r_final) begin
      r_addr  <= r_addr_next;
      r_cnt   <= r_cnt + 8'd1;
      r_data  <= r_err ? '0 : mem[r_addr_next[ADDR_W-1:AXSIZE_MAX]];
    end
  end

  assign rId   = r_id;
  assign rData = r_data;
  assign rResp = (rValid && r_err) ? 2'b10 : 2'b00;
  assign rLast = rValid && r_final;

endmodule

// File: doc/axi4_ram_slave.md
Name: axi4_ram_slave

Overview:
AXI4 responder (slave end of the Axi4 interface) backed by an on-chip byte-strobed RAM. It accepts FIXED, INCR and WRAP bursts on independent read and write paths, with one outstanding transaction per direction. It is the default memory target for interconnect and master-side benches, and a scratchpad in SoC builds.

Parameters:
BYTES, 4, data bus width in bytes (power of 2, 1..128); AXSIZE_MAX = log2(BYTES)
ADDR_W, 12, byte address width; RAM depth = 2^ADDR_W / BYTES words
ID_WIDTH, 4, ID width; values below 1 are treated as 1

Ports:
aclk  in  1  global clock
areset  in  1  synchronous active-high reset
awId awAddr awLen awSize awBurst  in  ID_WIDTH,ADDR_W,8,3,2  write address fields
awValid in 1 / awReady out 1  AW handshake
wData wStrb wLast  in  8*BYTES,BYTES,1  write data beat
wValid in 1 / wReady out 1  W handshake
bId bResp  out  ID_WIDTH,2  write response
bValid out 1 / bReady in 1  B handshake
arId arAddr arLen arSize arBurst  in  ID_WIDTH,ADDR_W,8,3,2  read address fields
arValid in 1 / arReady out 1  AR handshake
rId rData rResp rLast  out  ID_WIDTH,8*BYTES,2,1  read data beat
rValid out 1 / rReady in 1  R handshake
The lock, cache, prot, qos and region fields and wId are not ported; the block ignores them.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: every output is 0. awReady and arReady rise on the first cycle after areset deasserts.
- RAM contents are not reset.
- Reset mid-burst abandons the transaction. No further writes occur, and outputs go to their reset values on the next edge.
- Write FSM, W_IDLE:
  - awReady=1.
  - On an AW handshake, capture id, addr, len, size and burst, clear the beat counter and the error flag, then go to W_DATA.
- Write FSM, W_DATA:
  - wReady=1 and awReady=0.
  - On each W handshake, write the bytes enabled by wStrb to word addr[ADDR_W-1:AXSIZE_MAX], unless the error flag is set.
  - After each W handshake, advance the address and increment the counter.
  - On the beat where counter==len, go to W_RESP.
- Write FSM, W_RESP:
  - bValid=1, bId=captured id, bResp=OKAY(00) or SLVERR(10).
  - On the B handshake, go to W_IDLE (awReady=1 the next cycle).
- Write error flag (SLVERR):
  - Set at AW capture if size>AXSIZE_MAX, burst=11, or burst=WRAP with len not in {1,3,7,15}. No RAM writes then occur.
  - Also set if wLast does not equal (counter==len) on any beat. Writes continue in that case.
  - Burst length is always len+1 beats. wLast never terminates a burst early.
- Address generation, with inc = 1<<size:
  - FIXED: the address is unchanged.
  - INCR: next = (addr & ~(inc-1)) + inc, modulo 2^ADDR_W.
  - WRAP: lower = addr & ~((len+1)*inc - 1); next wraps to lower when it reaches lower + (len+1)*inc.
- Read FSM, R_IDLE:
  - arReady=1.
  - On an AR handshake, capture the fields and issue the RAM read of arAddr, then go to R_DATA.
- Read FSM, R_DATA:
  - rValid=1 starting the cycle after the AR handshake, so first-beat latency is 1 cycle. rId = captured id.
  - rValid stays high for the whole burst, so throughput is 1 beat/cycle.
  - The RAM read address is the next-beat address on an R handshake, otherwise the current address. rData is registered.
  - rData, rResp and rLast are held stable while rValid=1 and rReady=0.
  - rLast=1 on beat len. After the final handshake, go to R_IDLE, with arReady=1 the next cycle.
- Read errors: same rules as the AW capture checks. rResp=SLVERR and rData=0 on all len+1 beats.
- Read and write paths are fully independent and may be active in the same cycle.
- Same-word read and write in the same cycle: the read returns the old data (read-before-write).
- Narrow transfers: writes use wStrb as given. Reads return the full word.

Test Plan:
- Reset, then a single write: AW addr=0x010, len=0, size=2, INCR, id=5, wData=0xDEADBEEF, wStrb=F -> bValid with bId=5, bResp=00. Then AR addr=0x010 -> rData=0xDEADBEEF one cycle after the AR handshake, rLast=1, rResp=00.
- INCR len=3 write at 0xFFC with data 1,2,3,4 -> words 0xFFC, 0x000, 0x004, 0x008 hold 1,2,3,4. A read burst with rReady held low for 3 cycles on beat 1 -> data is held stable, then 1,2,3,4 is returned with rLast only on beat 4.
- WRAP len=3, size=2, addr=0x028 -> beat address sequence is 0x028, 0x02C, 0x020, 0x024. WRAP with len=2 -> SLVERR on all 3 beats, and RAM is unchanged.
- Write with wStrb=0101 over 0xFFFFFFFF preload and wData=0x11223344 -> the word reads back 0xFF22FF44. Write with wLast low on the final beat -> bResp=10 and data is still written.
- Concurrent read and write to the same word 0x040 (old value 0xA, new value 0xB) in the same cycle -> the read returns 0xA and a subsequent read returns 0xB. areset asserted mid write-burst (beat 2 of 4) -> wReady=0 and bValid=0 the next cycle, awReady=1 after release, and later beats are not written.
